// File: rtl/noc_pe_sink.sv
// Ejection-side PE: flit FIFO with backpressure, operand decode, K-selected ALU with
// an 8-cycle shift-add multiply. Optional parity checking via NOC_PE_PARITY_CHECK_EN.
module noc_pe_sink #(
  parameter int         BUS_WIDTH  = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] NODE_ID    = 4'd0
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] router_out,
  output logic                 buffer_in,
  output logic [15:0]          res_data,
  output logic [3:0]           res_src,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          pkt_count,
  output logic [7:0]           drop_count,
  output logic                 err_misroute,
  output logic                 parity_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALMOST_C = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t          state, state_nxt;
  logic [23:0]     mem [FIFO_DEPTH];
  logic [23:0]     head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            flit_v, par_ok, dst_ok, push, pop, overflow;
  logic [7:0]      a_q, b_q;
  logic [3:0]      k_q, src_q;
  logic [15:0]     acc;
  logic [2:0]      cnt;
  logic            unused_bits;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] alu(input logic [3:0] k, input logic [7:0] a,
                                      input logic [7:0] b, input logic [15:0] prod);
    logic [15:0] ax, bx;
    ax = {8'h00, a};
    bx = {8'h00, b};
    case (k)
      4'd0:    alu = ax + bx;
      4'd1:    alu = ax - bx;
      4'd2:    alu = ax & bx;
      4'd3:    alu = ax | bx;
      4'd4:    alu = ax ^ bx;
      4'd5:    alu = prod;
      4'd6:    alu = ax << b[2:0];
      4'd7:    alu = ax >> b[2:0];
      default: alu = ax;
    endcase
  endfunction

  assign unused_bits = ^router_out[30:28];
  assign flit_v = router_out[31];
`ifdef NOC_PE_PARITY_CHECK_EN
  assign par_ok = (router_out[30] == ^router_out[29:0]);
`else
  assign par_ok = 1'b1;
`endif
  assign dst_ok    = (router_out[27:24] == NODE_ID);
  assign head      = mem[rd_ptr];
  assign pop       = (state == IDLE) && (count != '0);
  // A full FIFO still accepts when the FSM frees a slot on the same edge.
  assign push      = flit_v && par_ok && dst_ok && ((count < DEPTH_C) || pop);
  assign overflow  = flit_v && par_ok && dst_ok && !push;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign res_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (count != '0) state_nxt = (head[19:16] == 4'd5) ? MUL : EXEC;
      EXEC: state_nxt = DONE;
      MUL:  if (cnt == 3'd7) state_nxt = EXEC;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      buffer_in    <= 1'b0;
      drop_count   <= '0;
      err_misroute <= 1'b0;
      pkt_count    <= '0;
      res_data     <= '0;
      res_src      <= '0;
      cnt          <= '0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      // One slot of margin covers the router's one-cycle reaction to buffer_in.
      buffer_in    <= (count_nxt >= ALMOST_C);
      err_misroute <= flit_v && par_ok && !dst_ok;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (overflow) drop_count <= sat_inc8(drop_count);
      if (pop) cnt <= '0;
      else if (state == MUL) cnt <= cnt + 3'd1;
      if (state == EXEC) begin
        res_data <= alu(k_q, a_q, b_q, acc);
        res_src  <= src_q;
      end
      if ((state == DONE) && res_ready) pkt_count <= pkt_count + 16'd1;
    end
  end

`ifdef NOC_PE_PARITY_CHECK_EN
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= flit_v && !par_ok;
  end
`else
  assign parity_err = 1'b0;
`endif

  // Datapath: FIFO storage, operand latch and shift-add accumulator.
  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= router_out[23:0];
    if (pop) begin
      {src_q, k_q, b_q, a_q} <= head;
      acc <= '0;
    end else if ((state == MUL) && b_q[cnt]) begin
      acc <= acc + ({8'h00, a_q} << cnt);
    end
  end

endmodule
